// File: rtl/latch_bank_ctrl.sv
// latch_bank_ctrl: round-robin write sequencer for a bank of gated D-latches with preset sweep.
// Optional shadow readback of the bank contents is enabled by defining LATCH_BANK_CTRL_SHADOW_EN.
module latch_bank_ctrl #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned AW        = 3,
  parameter int unsigned DW        = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned GATE_CYC  = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  input  logic                 preset_req,
`ifdef LATCH_BANK_CTRL_SHADOW_EN
  input  logic [AW-1:0]        rd_addr,
  output logic [DW-1:0]        rd_data,
`endif
  output logic [DW-1:0]        latch_d,
  output logic [(2**AW)-1:0]   latch_g,
  output logic                 latch_ge,
  output logic                 latch_pre,
  output logic                 busy
);

  localparam int unsigned NLATCH = 2**AW;
  localparam int unsigned CMAX01 = (SETUP_CYC > GATE_CYC) ? SETUP_CYC : GATE_CYC;
  localparam int unsigned CMAX   = (CMAX01 > HOLD_CYC) ? CMAX01 : HOLD_CYC;
  localparam int unsigned CW     = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int unsigned RW     = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    ST_PRESET = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_GATE   = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [RW-1:0]     rr;
  logic [RW-1:0]     gnt_q;
  logic [AW-1:0]     addr_q;
  logic [RW-1:0]     gnt_idx;
  logic [RW-1:0]     cand;
  logic              gnt_valid;
  logic              grant;

  logic [NREQ-1:0]   ack_nxt;
  logic [NLATCH-1:0] g_nxt;
  logic              ge_nxt;
  logic              pre_nxt;
  logic              busy_nxt;
  logic [DW-1:0]     d_nxt;

  // Round-robin pick: search starts one past the last granted requester
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = rr;
    cand      = rr;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = RW'((32'(rr) + k) % NREQ);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // State register plus registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_PRESET;
      cnt       <= '0;
      rr        <= RW'(NREQ - 1);
      gnt_q     <= '0;
      addr_q    <= '0;
      ack       <= '0;
      latch_g   <= '0;
      latch_ge  <= 1'b0;
      latch_pre <= 1'b1;
      busy      <= 1'b1;
      latch_d   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      if (grant) begin
        rr     <= gnt_idx;
        gnt_q  <= gnt_idx;
        addr_q <= req_addr[32'(gnt_idx) * AW +: AW];
      end
      ack       <= ack_nxt;
      latch_g   <= g_nxt;
      latch_ge  <= ge_nxt;
      latch_pre <= pre_nxt;
      busy      <= busy_nxt;
      latch_d   <= d_nxt;
    end
  end

  // Next-state and phase counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    grant     = 1'b0;
    case (state)
      ST_PRESET: if (cnt == CW'(GATE_CYC - 1)) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (preset_req) begin
          state_nxt = ST_PRESET;
        end else if (gnt_valid) begin
          state_nxt = ST_SETUP;
          grant     = 1'b1;
        end
      end
      ST_SETUP:  if (cnt == CW'(SETUP_CYC - 1)) state_nxt = ST_GATE;
      ST_GATE:   if (cnt == CW'(GATE_CYC - 1))  state_nxt = ST_HOLD;
      ST_HOLD:   if (cnt == CW'(HOLD_CYC - 1))  state_nxt = ST_IDLE;
      default:   state_nxt = ST_PRESET;
    endcase
    if (state_nxt != state || state_nxt == ST_IDLE) cnt_nxt = '0;
  end

  // Outputs are decoded from the upcoming state so they land registered with it
  always_comb begin
    ack_nxt  = '0;
    g_nxt    = '0;
    ge_nxt   = 1'b0;
    pre_nxt  = 1'b0;
    busy_nxt = (state_nxt != ST_IDLE);
    d_nxt    = latch_d;
    case (state_nxt)
      ST_PRESET: pre_nxt = 1'b1;
      ST_GATE: begin
        ge_nxt        = 1'b1;
        g_nxt[addr_q] = 1'b1;
      end
      ST_HOLD: if (cnt_nxt == CW'(HOLD_CYC - 1)) ack_nxt[gnt_q] = 1'b1;
      default: ;
    endcase
    if (grant) d_nxt = req_data[32'(gnt_idx) * DW +: DW];
  end

`ifdef LATCH_BANK_CTRL_SHADOW_EN
  logic [DW-1:0] shadow [NLATCH];

  // Shadow copy follows preset completion and each committed write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NLATCH; i++) shadow[i] <= '1;
      rd_data <= '0;
    end else begin
      if (state == ST_PRESET && state_nxt == ST_IDLE) begin
        for (int unsigned i = 0; i < NLATCH; i++) shadow[i] <= '1;
      end
      if (state == ST_GATE && state_nxt == ST_HOLD) shadow[addr_q] <= latch_d;
      rd_data <= shadow[rd_addr];
    end
  end
`endif

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Bench for latch_bank_ctrl: hand sequences, a vector table and random traffic against a
// transaction-schedule reference model.
module tb_latch_bank_ctrl;

  localparam int SETUP_C = 1;
  localparam int GATE_C  = 2;
  localparam int HOLD_C  = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [5:0]  req_addr;
  logic [15:0] req_data;
  logic [1:0]  ack;
  logic        preset_req;
  logic [7:0]  latch_d;
  logic [7:0]  latch_g;
  logic        latch_ge;
  logic        latch_pre;
  logic        busy;
`ifdef LATCH_BANK_CTRL_SHADOW_EN
  logic [2:0]  rd_addr;
  logic [7:0]  rd_data;
`endif

  latch_bank_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .preset_req(preset_req),
`ifdef LATCH_BANK_CTRL_SHADOW_EN
    .rd_addr(rd_addr), .rd_data(rd_data),
`endif
    .latch_d(latch_d), .latch_g(latch_g), .latch_ge(latch_ge),
    .latch_pre(latch_pre), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ack;
    logic [7:0] g;
    logic       ge;
    logic       pre;
    logic       busy;
    logic [7:0] d;
  } exp_t;

  int errors = 0;
  int checks = 0;

  exp_t       sched[$];
  exp_t       exp_cur;
  int         m_rr;
  logic [7:0] m_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] a, input logic [7:0] g, input logic ge,
                              input logic pre, input logic bsy, input logic [7:0] d);
    exp_t r;
    r.ack = a; r.g = g; r.ge = ge; r.pre = pre; r.busy = bsy; r.d = d;
    return r;
  endfunction

  // Reference model: on each idle decision, queue the whole transaction's cycle-by-cycle outputs
  task automatic model_edge();
    int w;
    logic [2:0] a;
    if (reset) begin
      sched.delete();
      m_rr = 1;
      m_d  = 8'h00;
      exp_cur = mk(2'b00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);
      for (int i = 1; i < GATE_C; i++) sched.push_back(mk(2'b00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00));
      sched.push_back(mk(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00));
      return;
    end
    if (sched.size() == 0) begin
      if (preset_req) begin
        for (int i = 0; i < GATE_C; i++) sched.push_back(mk(2'b00, 8'h00, 1'b0, 1'b1, 1'b1, m_d));
        sched.push_back(mk(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, m_d));
      end else begin
        w = -1;
        for (int k = 1; k <= 2; k++) begin
          int c;
          c = (m_rr + k) % 2;
          if (w < 0 && req[c]) w = c;
        end
        if (w >= 0) begin
          m_rr = w;
          m_d  = req_data[w*8 +: 8];
          a    = req_addr[w*3 +: 3];
          for (int i = 0; i < SETUP_C; i++) sched.push_back(mk(2'b00, 8'h00, 1'b0, 1'b0, 1'b1, m_d));
          for (int i = 0; i < GATE_C; i++)
            sched.push_back(mk(2'b00, 8'(1 << a), 1'b1, 1'b0, 1'b1, m_d));
          for (int i = 0; i < HOLD_C; i++)
            sched.push_back(mk((i == HOLD_C - 1) ? 2'(1 << w) : 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, m_d));
          sched.push_back(mk(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, m_d));
        end
      end
    end
    if (sched.size() == 0) exp_cur = mk(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, m_d);
    else exp_cur = sched.pop_front();
  endtask

  // One clock: advance the model, let the edge happen, compare every output
  task automatic step();
    exp_t got;
    model_edge();
    @(posedge clk);
    #1;
    got = {ack, latch_g, latch_ge, latch_pre, busy, latch_d};
    chk("model_outputs", 32'(got), 32'(exp_cur));
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] a, input logic [7:0] d);
    req[i] = v;
    req_addr[i*3 +: 3] = a;
    req_data[i*8 +: 8] = d;
  endtask

  task automatic do_write(input int i, input logic [2:0] a, input logic [7:0] d);
    bit done;
    done = 0;
    set_req(i, 1'b1, a, d);
    for (int n = 0; n < 20 && !done; n++) begin
      step();
      if (exp_cur.ack[i]) done = 1;
    end
    chk("write_done", 32'(done), 32'd1);
    req[i] = 1'b0;
    step();
  endtask

  typedef struct {
    int         idx;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] exp_g;
    logic [1:0] exp_ack;
  } vec_t;

  vec_t vecs[4];
  int   ack_cnt;
  int   last_ack;
  int   n;

  initial begin
    vecs[0] = '{idx: 0, addr: 3'd5, data: 8'hA5, exp_g: 8'b0010_0000, exp_ack: 2'b01};
    vecs[1] = '{idx: 1, addr: 3'd0, data: 8'h3C, exp_g: 8'b0000_0001, exp_ack: 2'b10};
    vecs[2] = '{idx: 0, addr: 3'd7, data: 8'hFF, exp_g: 8'b1000_0000, exp_ack: 2'b01};
    vecs[3] = '{idx: 1, addr: 3'd3, data: 8'h00, exp_g: 8'b0000_1000, exp_ack: 2'b10};

    reset = 1'b1; req = '0; req_addr = '0; req_data = '0; preset_req = 1'b0;
`ifdef LATCH_BANK_CTRL_SHADOW_EN
    rd_addr = '0;
`endif

    // Reset then preset sweep of exactly GATE_CYC cycles
    for (int i = 0; i < 3; i++) step();
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_g", 32'(latch_g), 32'd0);
    chk("reset_d", 32'(latch_d), 32'd0);
    reset = 1'b0;
    chk("rel_pre1", 32'(latch_pre), 32'd1);
    chk("rel_busy1", 32'(busy), 32'd1);
    step();
    chk("rel_pre2", 32'(latch_pre), 32'd1);
    step();
    chk("rel_pre_off", 32'(latch_pre), 32'd0);
    chk("rel_busy_off", 32'(busy), 32'd0);

    // Single writes from a vector table
    for (int v = 0; v < 4; v++) begin
      chk("vec_idle", 32'(busy), 32'd0);
      set_req(vecs[v].idx, 1'b1, vecs[v].addr, vecs[v].data);
      step();
      chk("vec_setup_d", 32'(latch_d), 32'(vecs[v].data));
      chk("vec_setup_g", 32'(latch_g), 32'd0);
      req_data[vecs[v].idx*8 +: 8] = ~vecs[v].data;
      req_addr[vecs[v].idx*3 +: 3] = ~vecs[v].addr;
      for (int c = 0; c < 2; c++) begin
        step();
        chk("vec_gate_g", 32'(latch_g), 32'(vecs[v].exp_g));
        chk("vec_gate_ge", 32'(latch_ge), 32'd1);
        chk("vec_gate_d", 32'(latch_d), 32'(vecs[v].data));
        chk("vec_gate_ack", 32'(ack), 32'd0);
      end
      step();
      chk("vec_hold_ack", 32'(ack), 32'(vecs[v].exp_ack));
      chk("vec_hold_g", 32'(latch_g), 32'd0);
      chk("vec_hold_d", 32'(latch_d), 32'(vecs[v].data));
      req[vecs[v].idx] = 1'b0;
      step();
      chk("vec_back_idle", 32'(busy), 32'd0);
      chk("vec_ack_pulse", 32'(ack), 32'd0);
    end

    // Two continuous requesters alternate, one ack per 5 cycles
    set_req(0, 1'b1, 3'd1, 8'h11);
    set_req(1, 1'b1, 3'd2, 8'h22);
    ack_cnt = 0; last_ack = 0; n = 0;
    while (ack_cnt < 4 && n < 40) begin
      step();
      n++;
      if (latch_ge) chk("alt_gate", 32'(latch_g), (ack_cnt % 2 == 0) ? 32'h02 : 32'h04);
      if (ack != 2'b00) begin
        chk("alt_ack_idx", 32'(ack), (ack_cnt % 2 == 0) ? 32'd1 : 32'd2);
        if (ack_cnt > 0) chk("alt_spacing", 32'(n - last_ack), 32'd5);
        last_ack = n;
        ack_cnt++;
      end
    end
    chk("alt_ack_count", 32'(ack_cnt), 32'd4);
    req = 2'b00;
    step();
    step();

    // Preset request and write request in the same idle cycle
    preset_req = 1'b1;
    set_req(1, 1'b1, 3'd6, 8'h66);
    step();
    chk("pp_pre1", 32'(latch_pre), 32'd1);
    chk("pp_ge1", 32'(latch_ge), 32'd0);
    preset_req = 1'b0;
    step();
    chk("pp_pre2", 32'(latch_pre), 32'd1);
    chk("pp_g2", 32'(latch_g), 32'd0);
    step();
    chk("pp_idle", 32'(busy), 32'd0);
    step();
    chk("pp_setup_d", 32'(latch_d), 32'h66);
    step();
    chk("pp_gate", 32'(latch_g), 32'h40);
    step();
    step();
    chk("pp_ack", 32'(ack), 32'd2);
    req[1] = 1'b0;
    step();

    // Reset during the gate phase of a write
    set_req(0, 1'b1, 3'd3, 8'h33);
    step();
    step();
    chk("rg_gate", 32'(latch_g), 32'h08);
    reset = 1'b1;
    req = 2'b00;
    step();
    chk("rg_g", 32'(latch_g), 32'd0);
    chk("rg_ge", 32'(latch_ge), 32'd0);
    chk("rg_pre", 32'(latch_pre), 32'd1);
    chk("rg_ack", 32'(ack), 32'd0);
    reset = 1'b0;
    step();
    chk("rg_sweep", 32'(latch_pre), 32'd1);
    chk("rg_noack", 32'(ack), 32'd0);
    step();
    chk("rg_idle", 32'(busy), 32'd0);

`ifdef LATCH_BANK_CTRL_SHADOW_EN
    do_write(0, 3'd7, 8'h3C);
    rd_addr = 3'd7;
    step();
    chk("shadow_rd", 32'(rd_data), 32'h3C);
    preset_req = 1'b1;
    step();
    preset_req = 1'b0;
    step();
    step();
    step();
    chk("shadow_preset", 32'(rd_data), 32'hFF);
`else
    do_write(1, 3'd4, 8'h5A);
`endif

    // Random traffic checked against the model every cycle
    for (int cyc = 0; cyc < 1500; cyc++) begin
      step();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 149) == 0) reset = 1'b1;
      preset_req = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < 2; i++) begin
        if (req[i] && exp_cur.ack[i] && $urandom_range(0, 1) == 1) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0)
          set_req(i, 1'b1, 3'($urandom), 8'($urandom));
        else if (req[i] && $urandom_range(0, 29) == 0) req[i] = 1'b0;
        if ($urandom_range(0, 7) == 0) begin
          req_addr[i*3 +: 3] = 3'($urandom);
          req_data[i*8 +: 8] = 8'($urandom);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/latch_bank_ctrl.md
Name: latch_bank_ctrl

Overview:
- Write sequencer and arbiter for a bank of 2**AW gated D-latches, each with async preset and gate enable.
- Shares a common latch data bus between NREQ requesters using round-robin arbitration.
- Generates per-latch gate strobes with programmable setup/gate/hold spacing so every latch sees stable D around its G pulse.
- Performs the bank preset sweep after reset and on request.

Parameters:
- NREQ, 2, number of requesters.
- AW, 3, latch address width; bank size NLATCH = 2**AW.
- DW, 8, latch data width.
- SETUP_CYC, 1, cycles latch_d is stable before the gate opens (>=1).
- GATE_CYC, 2, cycles latch_g/latch_ge are high; also the preset pulse length (>=1).
- HOLD_CYC, 1, cycles latch_d is held after the gate closes (>=1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  write request per requester; held until ack.
- req_addr  in  NREQ*AW  target latch, requester i at bits [i*AW +: AW].
- req_data  in  NREQ*DW  write data, requester i at bits [i*DW +: DW].
- ack  out  NREQ  one-hot, one-cycle completion pulse.
- preset_req  in  1  request a full-bank preset.
- latch_d  out  DW  shared latch data bus.
- latch_g  out  NLATCH  one-hot gate strobes.
- latch_ge  out  1  common gate enable.
- latch_pre  out  1  common preset to all latches.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: ack=0, latch_g=0, latch_ge=0, latch_d=0, latch_pre=1, busy=1, rr pointer=NREQ-1, state=PRESET with counter cleared.
- All outputs are registered.
- States:
  - PRESET: latch_pre=1 for GATE_CYC cycles, then IDLE.
  - IDLE: if preset_req, go to PRESET; else if any req, grant it and go to SETUP; else stay in IDLE.
  - SETUP: latch_d=granted data, latch_g=0, for SETUP_CYC cycles.
  - GATE: latch_ge=1 and latch_g[addr]=1 for GATE_CYC cycles.
  - HOLD: latch_g=0, latch_ge=0, latch_d unchanged, for HOLD_CYC cycles. ack[grant]=1 in the last HOLD cycle.
  - After HOLD, return to IDLE.
- Grant and request sampling:
  - Grant is taken on the IDLE edge. Address and data are registered at that edge; later changes on req_addr/req_data are ignored.
  - Arbitration is round-robin. Priority starts at (rr+1) mod NREQ, and rr is updated to the granted index.
- Priorities and simultaneous events:
  - preset_req wins over req when both are seen in IDLE. Pending req are served after PRESET.
  - preset_req outside IDLE is not latched; it is re-sampled in IDLE, and the requester holds it.
- Timing at defaults:
  - Grant edge to ack = 4 cycles.
  - One write per 5 cycles back-to-back (IDLE cycle included).
  - A requester dropping req on the edge after ack is not re-granted.
- Requester behaviour:
  - If req drops mid-transaction, the write still completes and ack still pulses.
- Invariants:
  - latch_d never changes while any latch_g bit is high.
  - At most one latch_g bit is high at a time.
  - latch_pre and latch_ge are never high together.
  - latch_g=0 outside GATE.
- Reset mid-operation: all outputs go immediately (next edge) to their reset values; the latch being written is then preset by the sweep.
- busy=0 only in IDLE.

Optional Feature:
- Macro LATCH_BANK_CTRL_SHADOW_EN.
- When defined:
  - Adds inputs rd_addr (AW) and output rd_data (DW).
  - Keeps a clocked shadow array of the bank contents.
  - Shadow entries are all ones after each PRESET completes.
  - An entry is updated at the GATE-to-HOLD transition of each write.
  - rd_data = shadow[rd_addr], registered, with 1-cycle latency.
- When undefined: no shadow storage and no rd_* ports.

Test Plan:
- Reset for 3 cycles, then release:
  - latch_pre=1, busy=1 for exactly 2 cycles after release.
  - Then latch_pre=0, busy=0.
- req[0]=1, addr=5, data=0xA5 in IDLE:
  - latch_d=0xA5 the next cycle.
  - latch_g=8'b0010_0000 and latch_ge=1 for 2 cycles.
  - ack[0]=1 in the 4th cycle after the grant edge.
  - latch_d stays 0xA5 throughout.
- req[0] and req[1] high continuously (addr 1/2, data 0x11/0x22):
  - grants alternate 0,1,0,1.
  - One ack every 5 cycles.
  - Gates alternate latch_g bit 1, bit 2.
- preset_req and req[1] rise in the same IDLE cycle:
  - PRESET runs first (latch_pre=1 for 2 cycles, no gate).
  - Then the req[1] write runs.
- Assert reset during GATE of a write to addr 3:
  - latch_g=0, latch_ge=0, latch_pre=1 at the next edge.
  - No ack.
  - Preset sweep follows release.
- With LATCH_BANK_CTRL_SHADOW_EN:
  - Write 0x3C to addr 7, then set rd_addr=7: rd_data=0x3C one cycle later.
  - After preset_req, rd_data=0xFF.
